cam_init_seq: RTL and testbench

CAM_INIT_SEQ -- requirements
Module: cam_init_seq

---
 rtl/cam_init_seq.sv | 175 +++++++++++++++++
 tb/tb_cam_init_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_init_seq.sv
// Camera init sequencer: walks a register table, issues each entry to the SCCB
// setup stage and, for writes, reads the register back with a bounded retry.
module cam_init_seq #(
  parameter int TABLE_DEPTH = 128,
  parameter int IDX_W       = 7,
  parameter int VERIFY      = 1,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IDX_W-1:0] tbl_idx_o,
  input  logic [16:0]      tbl_data_i,
  output logic [16:0]      rw_cmd_o,
  output logic             rw_cmd_valid_o,
  input  logic             rw_cmd_ready_i,
  input  logic [16:0]      rw_resp_i,
  input  logic             rw_resp_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_idx_o
);

  localparam int             RETRY_W    = $clog2(MAX_RETRY + 1);
  localparam logic [16:0]    END_MARK   = 17'h1FFFF;
  localparam logic [16:0]    DELAY_MARK = 17'h1F0F0;
  localparam logic [IDX_W:0] DEPTH_END  = (IDX_W + 1)'(TABLE_DEPTH);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_RESP, VRFY_ISSUE, VRFY_WAIT, DONE, ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W:0]     idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [16:0]        entry_q, entry_d;
  logic [IDX_W-1:0]   tbl_idx_q, tbl_idx_d;
  logic [16:0]        cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;

  logic [IDX_W:0]     idx_inc_s;
  logic [RETRY_W-1:0] retry_inc_s;
  logic               verify_req_s;

  assign idx_inc_s    = idx_q + (IDX_W + 1)'(1);
  assign retry_inc_s  = retry_q + RETRY_W'(1);
  assign verify_req_s = (VERIFY == 1) && entry_q[16] && (entry_q != DELAY_MARK);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    entry_d     = entry_q;
    tbl_idx_d   = tbl_idx_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    done_d      = done_q;
    error_d     = error_q;
    err_idx_d   = err_idx_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          idx_d     = '0;
          retry_d   = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          tbl_idx_d = '0;
          state_d   = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        entry_d = tbl_data_i;
        if ((tbl_data_i == END_MARK) || (idx_q == DEPTH_END)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cmd_d       = tbl_data_i;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE, VRFY_ISSUE: begin
        if (cmd_valid_q && rw_cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = (state_q == ISSUE) ? WAIT_RESP : VRFY_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      WAIT_RESP: begin
        if (!rw_resp_valid_i) begin
          state_d = state_q;
        end else if (verify_req_s) begin
          cmd_d       = {1'b0, entry_q[15:8], 8'h00};
          cmd_valid_d = 1'b1;
          state_d     = VRFY_ISSUE;
        end else begin
          idx_d     = idx_inc_s;
          retry_d   = '0;
          tbl_idx_d = idx_inc_s[IDX_W-1:0];
          state_d   = FETCH;
        end
      end
      VRFY_WAIT: begin
        // A mismatched readback rewrites the same entry until attempts run out.
        if (!rw_resp_valid_i) begin
          state_d = state_q;
        end else if (rw_resp_i[7:0] == entry_q[7:0]) begin
          idx_d     = idx_inc_s;
          retry_d   = '0;
          tbl_idx_d = idx_inc_s[IDX_W-1:0];
          state_d   = FETCH;
        end else if (32'(retry_inc_s) < MAX_RETRY) begin
          retry_d     = retry_inc_s;
          cmd_d       = entry_q;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end else begin
          err_idx_d = idx_q[IDX_W-1:0];
          error_d   = 1'b1;
          state_d   = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, DONE, ERROR});
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      entry_q     <= '0;
      tbl_idx_q   <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      entry_q     <= entry_d;
      tbl_idx_q   <= tbl_idx_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign tbl_idx_o      = tbl_idx_q;
  assign rw_cmd_o       = cmd_q;
  assign rw_cmd_valid_o = cmd_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign err_idx_o      = err_idx_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Scoreboard bench for cam_init_seq: a table-level reference model predicts the
// command stream and final status; a monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_cam_init_seq;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int MR    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [IW-1:0] tbl_idx_o;
  logic [16:0]   tbl_data_i = 17'h0;
  logic [16:0]   rw_cmd_o;
  logic          rw_cmd_valid_o;
  logic          rw_cmd_ready_i = 1'b0;
  logic [16:0]   rw_resp_i = 17'h0;
  logic          rw_resp_valid_i = 1'b0;
  logic          busy_o, done_o, error_o;
  logic [IW-1:0] err_idx_o;

  always #5 clk = ~clk;

  cam_init_seq #(.TABLE_DEPTH(DEPTH), .IDX_W(IW), .VERIFY(1), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .tbl_idx_o(tbl_idx_o), .tbl_data_i(tbl_data_i),
    .rw_cmd_o(rw_cmd_o), .rw_cmd_valid_o(rw_cmd_valid_o), .rw_cmd_ready_i(rw_cmd_ready_i),
    .rw_resp_i(rw_resp_i), .rw_resp_valid_i(rw_resp_valid_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o)
  );

  logic [16:0] tbl [DEPTH];
  int          bad [DEPTH];       // number of failing readbacks per entry
  bit          corrupt [256];     // per read command, in issue order
  logic [16:0] exp_q [$];
  bit          exp_done, exp_err;
  int          exp_erridx;
  int          checks = 0, errors = 0;
  int          run_id = 0, ready_mode = 0, dly_min = 0, dly_max = 3, spur_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Table ROM with one cycle of read latency.
  initial begin : table_rom
    logic [IW-1:0] idx_prev;
    idx_prev = '0;
    forever begin
      @(posedge clk); #1;
      tbl_data_i = tbl[idx_prev];
      idx_prev   = tbl_idx_o;
    end
  end

  // SCCB setup-stage model: register file, delayed responses, corrupted readbacks.
  initial begin : responder
    logic [7:0]  regs [256];
    logic [16:0] c, pend_resp;
    bit          pend;
    int          seen_run, nread, stall_seen, spur_done, dly;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    pend = 1'b0; seen_run = -1; nread = 0; stall_seen = 0; spur_done = 0; dly = 0;
    pend_resp = 17'h0;
    forever begin
      @(posedge clk); #1;
      if (seen_run != run_id) begin seen_run = run_id; nread = 0; stall_seen = 0; end
      if (!rst_n) pend = 1'b0;
      rw_resp_valid_i = 1'b0;
      if (spur_done != spur_cnt) begin
        spur_done = spur_cnt;
        rw_resp_valid_i = 1'b1;
        rw_resp_i = 17'h00A5A;
      end else if (pend) begin
        if (dly == 0) begin
          rw_resp_valid_i = 1'b1;
          rw_resp_i = pend_resp;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      case (ready_mode)
        1:       rw_cmd_ready_i = ($urandom_range(0, 9) < 6);
        2:       rw_cmd_ready_i = (stall_seen >= 10);
        default: rw_cmd_ready_i = 1'b1;
      endcase
      @(negedge clk);
      if (ready_mode == 2 && rw_cmd_valid_o && !rw_cmd_ready_i && stall_seen < 10) stall_seen++;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (rw_cmd_valid_o && rw_cmd_ready_i) begin
        c = rw_cmd_o;
        if (c[16]) begin
          regs[c[15:8]] = c[7:0];
          pend_resp = c;
        end else begin
          pend_resp = {1'b0, c[15:8], corrupt[nread] ? ~regs[c[15:8]] : regs[c[15:8]]};
          nread++;
        end
        pend = 1'b1;
        dly = $urandom_range(dly_min, dly_max);
      end
    end
  end

  // Monitor: handshake scoreboard, command hold while stalled, single outstanding.
  initial begin : monitor
    bit          pv, pr, outstanding;
    logic [16:0] pc, e;
    pv = 1'b0; pr = 1'b0; outstanding = 1'b0; pc = 17'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pv = 1'b0; outstanding = 1'b0; continue; end
      if (rw_resp_valid_i) outstanding = 1'b0;
      if (pv && !pr) chk("cmd_hold", 32'({rw_cmd_valid_o, rw_cmd_o}), 32'({1'b1, pc}));
      if (rw_cmd_valid_o) chk("one_outstanding", 32'(outstanding), 32'd0);
      if (rw_cmd_valid_o && rw_cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 32'(rw_cmd_o), 32'h1FFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", 32'(rw_cmd_o), 32'(e));
        end
        outstanding = 1'b1;
      end
      pv = rw_cmd_valid_o; pr = rw_cmd_ready_i; pc = rw_cmd_o;
    end
  end

  // Reference model: expected command stream and outcome from the table alone.
  task automatic build_model();
    int nr;
    logic [16:0] e;
    nr = 0;
    exp_q.delete();
    exp_done = 1'b1; exp_err = 1'b0; exp_erridx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = tbl[i];
      if (e == 17'h1FFFF) break;
      if (!e[16]) begin
        exp_q.push_back(e);
        corrupt[nr] = 1'($urandom_range(0, 1));
        nr++;
      end else if (e == 17'h1F0F0) begin
        exp_q.push_back(e);
      end else begin
        for (int a = 0; a < MR; a++) begin
          exp_q.push_back(e);
          exp_q.push_back({1'b0, e[15:8], 8'h00});
          corrupt[nr] = (a < bad[i]);
          nr++;
          if (a >= bad[i]) break;
        end
        if (bad[i] >= MR) begin exp_done = 1'b0; exp_err = 1'b1; exp_erridx = i; break; end
      end
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < DEPTH; i++) begin tbl[i] = 17'h1FFFF; bad[i] = 0; end
  endtask

  task automatic rand_table();
    int endpos;
    logic [16:0] e;
    endpos = $urandom_range(0, DEPTH + 4);
    for (int i = 0; i < DEPTH; i++) begin
      case ($urandom_range(0, 9))
        0:       e = 17'h1F0F0;
        1, 2:    e = {1'b0, 8'($urandom), 8'($urandom)};
        default: e = {1'b1, 8'($urandom), 8'($urandom)};
      endcase
      if (e == 17'h1FFFF) e = 17'h1FFFE;
      if (i == endpos) e = 17'h1FFFF;
      tbl[i] = e;
      bad[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, MR) : 0;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 32'({tbl_idx_o, rw_cmd_o, rw_cmd_valid_o, busy_o, done_o, error_o, err_idx_o}), 32'd0);
  endtask

  task automatic run_seq(input string nm, input bit poke);
    int k;
    bit fin;
    build_model();
    run_id++;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    k = $urandom_range(1, 40);
    fin = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o || error_o) begin fin = 1'b1; break; end
      start_i = (i == k) && busy_o && poke;
    end
    start_i = 1'b0;
    chk({nm, "_finished"}, 32'(fin), 32'd1);
    chk({nm, "_done"}, 32'(done_o), 32'(exp_done));
    chk({nm, "_error"}, 32'(error_o), 32'(exp_err));
    chk({nm, "_busy"}, 32'(busy_o), 32'd0);
    chk({nm, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
    if (exp_err) chk({nm, "_err_idx"}, 32'(err_idx_o), 32'(exp_erridx));
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit hs;
    clear_table();
    #2 rst_n = 1'b0;
    #1 chk_idle("reset_async");
    repeat (3) @(negedge clk);
    chk_idle("reset_held");
    rst_n = 1'b1;

    // Basic table: write, delay marker, end marker.
    tbl[0] = 17'h11280; tbl[1] = 17'h1F0F0; tbl[2] = 17'h1FFFF;
    ready_mode = 0;
    run_seq("basic", 1'b0);
    // Same table with the setup stage stalled for 10 cycles.
    ready_mode = 2;
    run_seq("stall", 1'b0);

    // Persistent readback failure on entry 2.
    ready_mode = 0;
    clear_table();
    tbl[0] = 17'h11011; tbl[1] = 17'h02000; tbl[2] = 17'h13055;
    bad[2] = MR;
    run_seq("retry_fail", 1'b0);
    chk("retry_fail_err_idx2", 32'(err_idx_o), 32'd2);
    // Single failing readback then success.
    bad[2] = 1;
    run_seq("retry_ok", 1'b0);

    // No end marker: the whole table is issued.
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = {1'b1, 8'(i + 8'h40), 8'(8'h11 * i + 8'h3)};
      bad[i] = 0;
    end
    ready_mode = 1;
    run_seq("full_depth", 1'b1);

    // Reset while waiting for a response, then a stray response after release.
    ready_mode = 0; dly_min = 20; dly_max = 20;
    clear_table();
    tbl[0] = 17'h11280;
    build_model();
    run_id++;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rw_cmd_valid_o && rw_cmd_ready_i) begin hs = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_wait_handshake", 32'(hs), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle("rst_in_wait");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spur_cnt++;
    repeat (20) @(negedge clk);
    chk_idle("after_spurious_resp");
    dly_min = 0; dly_max = 3;
    run_seq("post_reset", 1'b0);

    // Randomized tables, delays, ready patterns and ignored start pulses.
    for (int r = 0; r < 30; r++) begin
      rand_table();
      ready_mode = $urandom_range(0, 1);
      run_seq($sformatf("rand%0d", r), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
